oled_spi_arb: RTL and testbench

OLED_SPI_ARB -- requirements
Module: oled_spi_arb

---
 rtl/oled_pkg.sv | 8 +
 rtl/spi_byte_tx.sv | 49 ++++
 rtl/oled_spi_arb.sv | 107 ++++++++++
 tb/tb_oled_spi_arb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// oled_pkg: shared state encoding, grant constants and SPI idle level for the OLED SPI arbiter
package oled_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_WAIT, S_GAP} state_t;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0 = 2'b01;
  localparam logic [1:0] GNT_1 = 2'b10;
  localparam logic SCLK_IDLE = 1'b1;
endpackage

// File: rtl/spi_byte_tx.sv
// spi_byte_tx: mode-3 SPI byte serializer, MSB first, sclk half-period of CLK_DIV clk cycles
module spi_byte_tx import oled_pkg::*; #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       sclk,
  output logic       sdata,
  output logic       done
);
  localparam logic [7:0] DIV_M = 8'(CLK_DIV - 1);
  logic       active;
  logic [7:0] div;
  logic [2:0] bits;
  logic [6:0] sh;
  logic       tick;
  assign tick = active && div == DIV_M;
  // done fires during the last cycle of bit 0's high phase so the FSM leaves SHIFT on time
  assign done = tick && sclk && bits == 3'd7;
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      sclk <= SCLK_IDLE;
      sdata <= 1'b0;
      div <= '0;
      bits <= '0;
      sh <= '0;
    end else if (load) begin
      active <= 1'b1;
      sclk <= ~SCLK_IDLE;
      sdata <= data[7];
      sh <= data[6:0];
      div <= '0;
      bits <= '0;
    end else if (tick) begin
      div <= '0;
      if (!sclk) sclk <= 1'b1;
      else if (bits == 3'd7) active <= 1'b0;
      else begin
        sclk <= 1'b0;
        sdata <= sh[6];
        sh <= {sh[5:0], 1'b0};
        bits <= bits + 3'd1;
      end
    end else if (active) div <= div + 8'd1;
  end
endmodule

// File: rtl/oled_spi_arb.sv
// oled_spi_arb: two-requester arbiter driving an OLED SPI link with transaction lock.
// Define OLED_ARB_PRIO_EN for fixed priority (req0 wins ties) instead of round-robin.
module oled_spi_arb import oled_pkg::*; #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_dc,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_dc,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       sclk,
  output logic       sdata,
  output logic       cs,
  output logic       d_cn,
  output logic [1:0] grant,
  output logic       busy
);
  localparam logic [7:0] GAP_M = 8'(CS_GAP - 1);
  state_t     state;
  logic [1:0] ready;
  logic [1:0] win;
  logic [7:0] gap;
  logic       pref;
  logic       last;
  logic       done;
  logic       own_valid;
  logic       own_dc;
  logic       own_last;
  logic [7:0] own_data;
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign own_valid = grant[1] ? req1_valid : req0_valid;
  assign own_data = grant[1] ? req1_data : req0_data;
  assign own_dc = grant[1] ? req1_dc : req0_dc;
  assign own_last = grant[1] ? req1_last : req0_last;
`ifdef OLED_ARB_PRIO_EN
  assign win = req0_valid ? GNT_0 : req1_valid ? GNT_1 : GNT_NONE;
`else
  // pref=1 means req1 is favored on a tie (req0 was served last)
  assign win = (req0_valid && req1_valid) ? (pref ? GNT_1 : GNT_0) :
               req0_valid ? GNT_0 : req1_valid ? GNT_1 : GNT_NONE;
`endif
  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk(clk),
    .reset(reset),
    .load(state == S_LOAD),
    .data(own_data),
    .sclk(sclk),
    .sdata(sdata),
    .done(done)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cs <= 1'b1;
      grant <= GNT_NONE;
      ready <= 2'b00;
      d_cn <= 1'b0;
      busy <= 1'b0;
      last <= 1'b0;
      pref <= 1'b0;
      gap <= '0;
    end else begin
      ready <= 2'b00;
      case (state)
        S_IDLE: if (win != GNT_NONE) begin
          state <= S_LOAD;
          cs <= 1'b0;
          grant <= win;
          ready <= win;
          busy <= 1'b1;
        end
        S_LOAD: begin
          state <= S_SHIFT;
          d_cn <= own_dc;
          last <= own_last;
        end
        S_SHIFT: if (done) begin
          if (last) begin
            state <= S_GAP;
            cs <= 1'b1;
            grant <= GNT_NONE;
            gap <= '0;
            pref <= ~grant[1];
          end else state <= S_WAIT;
        end
        S_WAIT: if (own_valid) begin
          state <= S_LOAD;
          ready <= grant;
        end
        S_GAP: if (gap == GAP_M) begin
          state <= S_IDLE;
          busy <= 1'b0;
        end else gap <= gap + 8'd1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_oled_spi_arb.sv
// tb_oled_spi_arb: directed checks of arbitration, SPI framing, transaction lock and reset abort
module tb_oled_spi_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 1'b0, req0_dc = 1'b0, req0_last = 1'b0, req0_ready;
  logic req1_valid = 1'b0, req1_dc = 1'b0, req1_last = 1'b0, req1_ready;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic sclk, sdata, cs, d_cn, busy;
  logic [1:0] grant;
  int ncmp = 0, nerr = 0;
  int nrise = 0, nr0 = 0, nr1 = 0;
  logic [7:0] rx = 8'h00;
  logic sclk_q = 1'b1;
  logic [1:0] g1;
  int s0, s1, sr, lows;

  oled_spi_arb #(.CLK_DIV(2), .CS_GAP(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_dc(req0_dc),
    .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_dc(req1_dc),
    .req1_last(req1_last), .req1_ready(req1_ready),
    .sclk(sclk), .sdata(sdata), .cs(cs), .d_cn(d_cn), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // mid-cycle monitor: captures bits on sclk rising edges and counts ready pulses
  always @(negedge clk) begin
    if (sclk && !sclk_q) begin
      rx <= {rx[6:0], sdata};
      nrise <= nrise + 1;
    end
    sclk_q <= sclk;
    if (req0_ready) nr0 <= nr0 + 1;
    if (req1_ready) nr1 <= nr1 + 1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    cyc(3);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_dcn", 32'(d_cn), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    reset = 1'b0;
    cyc(1);
    // single byte 0xA5 from req0
    req0_valid = 1'b1; req0_data = 8'hA5; req0_dc = 1'b0; req0_last = 1'b1;
    cyc(1);
    chk("t1_load_cs", 32'(cs), 32'd0);
    chk("t1_load_grant", 32'(grant), 32'b01);
    chk("t1_load_ready", 32'({req1_ready, req0_ready}), 32'b01);
    chk("t1_load_sclk", 32'(sclk), 32'd1);
    req0_valid = 1'b0;
    sr = nrise;
    cyc(1);
    chk("t1_first_fall", 32'(sclk), 32'd0);
    chk("t1_bit7", 32'(sdata), 32'd1);
    chk("t1_dcn", 32'(d_cn), 32'd0);
    cyc(1);
    chk("t1_ready_once", 32'(req0_ready), 32'd0);
    cyc(28);
    chk("t1_shift30_low", 32'(sclk), 32'd0);
    cyc(2);
    chk("t1_shift32_sclk", 32'(sclk), 32'd1);
    chk("t1_shift32_cs", 32'(cs), 32'd0);
    cyc(1);
    chk("t1_gap_cs", 32'(cs), 32'd1);
    chk("t1_gap_grant", 32'(grant), 32'd0);
    chk("t1_gap_busy", 32'(busy), 32'd1);
    chk("t1_rx", 32'(rx), 32'hA5);
    chk("t1_rises", 32'(nrise - sr), 32'd8);
    cyc(3);
    chk("t1_gap4_busy", 32'(busy), 32'd1);
    cyc(1);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_cs", 32'(cs), 32'd1);
    // tie after req0 was served
`ifdef OLED_ARB_PRIO_EN
    g1 = 2'b01;
`else
    g1 = 2'b10;
`endif
    req0_valid = 1'b1; req0_data = 8'h11; req0_dc = 1'b0; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h22; req1_dc = 1'b1; req1_last = 1'b1;
    cyc(1);
    chk("t2_tie1_grant", 32'(grant), 32'(g1));
    chk("t2_tie1_ready", 32'({req1_ready, req0_ready}), 32'(g1));
    if (g1[0]) req0_valid = 1'b0; else req1_valid = 1'b0;
    cyc(1);
    chk("t2_tie1_dcn", 32'(d_cn), 32'(g1[1]));
    cyc(32);
    chk("t2_tie1_rx", 32'(rx), g1[0] ? 32'h11 : 32'h22);
    req0_valid = 1'b1; req1_valid = 1'b1;
    cyc(4);
    chk("t2_idle_grant", 32'(grant), 32'd0);
    cyc(1);
    chk("t2_tie2_grant", 32'(grant), 32'b01);
    chk("t2_tie2_ready", 32'({req1_ready, req0_ready}), 32'b01);
    req0_valid = 1'b0;
    cyc(33);
    chk("t2_tie2_rx", 32'(rx), 32'h11);
    cyc(5);
    chk("t2_req1_grant", 32'(grant), 32'b10);
    req0_valid = 1'b1; req0_data = 8'h3C; req0_dc = 1'b1; req0_last = 1'b0;
    cyc(33);
    chk("t2_req1_rx", 32'(rx), 32'h22);
    cyc(5);
    chk("t3_grant", 32'(grant), 32'b01);
    chk("t3_ready", 32'(req0_ready), 32'd1);
    // three-byte locked transaction with a stall; req1 stays valid throughout
    s1 = nr1;
    cyc(1);
    req0_data = 8'hFF; req0_valid = 1'b0;
    chk("t3_dcn", 32'(d_cn), 32'd1);
    cyc(32);
    chk("t3_wait_cs", 32'(cs), 32'd0);
    chk("t3_wait_grant", 32'(grant), 32'b01);
    chk("t3_wait_busy", 32'(busy), 32'd1);
    chk("t3_latched_rx", 32'(rx), 32'h3C);
    sr = nrise;
    cyc(49);
    chk("t3_stall_sclk", 32'(sclk), 32'd1);
    chk("t3_stall_cs", 32'(cs), 32'd0);
    chk("t3_stall_edges", 32'(nrise - sr), 32'd0);
    chk("t3_stall_req1", 32'(nr1 - s1), 32'd0);
    req0_valid = 1'b1; req0_data = 8'h5A; req0_last = 1'b0;
    cyc(1);
    chk("t3_b2_ready", 32'(req0_ready), 32'd1);
    chk("t3_b2_cs", 32'(cs), 32'd0);
    cyc(33);
    chk("t3_b2_rx", 32'(rx), 32'h5A);
    req0_data = 8'h96; req0_last = 1'b1;
    cyc(1);
    chk("t3_b3_grant", 32'(grant), 32'b01);
    chk("t3_b3_cs", 32'(cs), 32'd0);
    req0_valid = 1'b0;
    cyc(33);
    chk("t3_b3_rx", 32'(rx), 32'h96);
    chk("t3_gap_cs", 32'(cs), 32'd1);
    chk("t3_req1_locked", 32'(nr1 - s1), 32'd0);
    cyc(4);
    chk("t3_idle_grant", 32'(grant), 32'd0);
    cyc(1);
    chk("t3_req1_grant", 32'(grant), 32'b10);
    chk("t3_req1_ready", 32'(req1_ready), 32'd1);
    req1_valid = 1'b0;
    cyc(37);
    // reset in the 10th SHIFT cycle
    req0_valid = 1'b1; req0_data = 8'hC3; req0_last = 1'b1;
    cyc(1);
    req0_valid = 1'b0;
    cyc(10);
    chk("t4_mid_shift", 32'(sclk), 32'd0);
    reset = 1'b1;
    s0 = nr0; s1 = nr1;
    cyc(1);
    chk("t4_cs", 32'(cs), 32'd1);
    chk("t4_sclk", 32'(sclk), 32'd1);
    chk("t4_grant", 32'(grant), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    lows = 0;
    repeat (20) begin
      cyc(1);
      if (!sclk || !cs) lows++;
    end
    chk("t4_no_edges", 32'(lows), 32'd0);
    chk("t4_no_ready", 32'((nr0 - s0) + (nr1 - s1)), 32'd0);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
